// File: rtl/quick_add_round_ctrl.sv
// Round sequencer for the quick-add game: drives the shared up/down counter as the
// round timer, arbitrates the two buzzers and reports winner and remaining time.
module quick_add_round_ctrl (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [15:0] load_val_i,
    input  logic        tick_i,
    input  logic        add_time_i,
    input  logic        p1_buzz_i,
    input  logic        p2_buzz_i,
    input  logic [15:0] ctr_q_i,
    output logic        ctr_up_o,
    output logic        ctr_dw_o,
    output logic        ctr_ld_o,
    output logic [15:0] ctr_din_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  winner_o,
    output logic [15:0] time_left_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    state_t      state_q, state_d;
    logic [15:0] din_q, din_d;
    logic        ld_q, ld_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:0]  winner_q, winner_d;
    logic [15:0] time_left_q, time_left_d;
    logic        prio_q, prio_d;        // 0: next tie goes to P1, 1: to P2

    logic        decide_s;
    logic        flip_s;
    logic [1:0]  win_s;
    logic        up_s;
    logic        dw_s;

    // Round decision: single buzz, then tie by priority, then timeout.
    always_comb begin
        decide_s = 1'b0;
        flip_s   = 1'b0;
        win_s    = WIN_NONE;
        if (p1_buzz_i ^ p2_buzz_i) begin
            decide_s = 1'b1;
            win_s    = p1_buzz_i ? WIN_P1 : WIN_P2;
        end else if (p1_buzz_i & p2_buzz_i) begin
            decide_s = 1'b1;
            flip_s   = 1'b1;
            win_s    = prio_q ? WIN_P2 : WIN_P1;
        end else if (ctr_q_i == 16'h0000) begin
            decide_s = 1'b1;
            win_s    = WIN_NONE;
        end else begin
            decide_s = 1'b0;
        end
    end

    // Next-state, registered output values and combinational counter enables.
    always_comb begin
        state_d     = state_q;
        din_d       = 16'h0000;
        ld_d        = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        winner_d    = winner_q;
        time_left_d = time_left_q;
        prio_d      = prio_q;
        up_s        = 1'b0;
        dw_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = ST_LOAD;
                    din_d       = load_val_i;
                    ld_d        = 1'b1;
                    busy_d      = 1'b1;
                    winner_d    = WIN_NONE;
                    time_left_d = 16'h0000;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
                busy_d  = 1'b1;
            end
            ST_RUN: begin
                if (decide_s) begin
                    // Counter is frozen in the decision cycle so time_left matches ctr_q_i.
                    state_d     = ST_RESULT;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    winner_d    = win_s;
                    time_left_d = ctr_q_i;
                    if (flip_s) begin
                        prio_d = ~prio_q;
                    end else begin
                        prio_d = prio_q;
                    end
                end else begin
                    dw_s = tick_i & ~add_time_i & (ctr_q_i != 16'h0000);
                    up_s = add_time_i & ~tick_i & (ctr_q_i != 16'hFFFF);
                end
            end
            ST_RESULT: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            din_q       <= 16'h0000;
            ld_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            winner_q    <= WIN_NONE;
            time_left_q <= 16'h0000;
            prio_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            din_q       <= din_d;
            ld_q        <= ld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            winner_q    <= winner_d;
            time_left_q <= time_left_d;
            prio_q      <= prio_d;
        end
    end

    assign ctr_up_o    = up_s;
    assign ctr_dw_o    = dw_s;
    assign ctr_ld_o    = ld_q;
    assign ctr_din_o   = din_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign winner_o    = winner_q;
    assign time_left_o = time_left_q;

endmodule
